// File: rtl/dmem_mmio_responder.sv
// Data-memory slave for the Whack-A-Mole build: a word RAM plus a small MMIO bank
// (buttons, LEDs, prescaled timer, score). Every access returns data one clock later.
module dmem_mmio_responder #(
    parameter int RAM_WORDS = 1024,
    parameter int NUM_BTN   = 9,
    parameter int TICK_DIV  = 50000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [11:0]        address_dmem,
    input  logic [31:0]        d_dmem,
    input  logic               wren_dmem,
    output logic [31:0]        q_dmem,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] led_out,
    output logic [15:0]        score_out
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [11:0]   RAM_TOP  = 12'(RAM_WORDS);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [11:0] ADDR_BTN_STATUS = 12'hF00;
    localparam logic [11:0] ADDR_BTN_LEVEL  = 12'hF01;
    localparam logic [11:0] ADDR_LED        = 12'hF02;
    localparam logic [11:0] ADDR_TIMER      = 12'hF03;
    localparam logic [11:0] ADDR_TIMER_CLR  = 12'hF04;
    localparam logic [11:0] ADDR_SCORE      = 12'hF05;

    logic [31:0]        ram [RAM_WORDS];
    logic [NUM_BTN-1:0] btn_sync_p0, btn_sync_p1, btn_prev_p2;
    logic [NUM_BTN-1:0] btn_flags, btn_rise, status_clr;
    logic [31:0]        timer_cnt;
    logic [PW-1:0]      prescale;
    logic [31:0]        rd_data;
    logic               is_ram, rd_status, wr_led, wr_score, wr_timer_clr, tick;
    logic [AW-1:0]      ram_idx;

    assign is_ram       = (address_dmem < RAM_TOP);
    assign ram_idx      = address_dmem[AW-1:0];
    assign rd_status    = (address_dmem == ADDR_BTN_STATUS) && !wren_dmem;
    assign wr_led       = (address_dmem == ADDR_LED) && wren_dmem;
    assign wr_score     = (address_dmem == ADDR_SCORE) && wren_dmem;
    assign wr_timer_clr = (address_dmem == ADDR_TIMER_CLR) && wren_dmem;
    assign tick         = (prescale == PRE_LAST);
    assign btn_rise     = btn_sync_p1 & ~btn_prev_p2;
    // A status read clears exactly the flags it returned; a coincident new edge survives.
    assign status_clr   = rd_status ? btn_flags : '0;

    always_comb begin
        rd_data = '0;
        if (is_ram) begin
            rd_data = ram[ram_idx];
        end else begin
            case (address_dmem)
                ADDR_BTN_STATUS: rd_data[NUM_BTN-1:0] = btn_flags;
                ADDR_BTN_LEVEL:  rd_data[NUM_BTN-1:0] = btn_sync_p1;
                ADDR_LED:        rd_data[NUM_BTN-1:0] = led_out;
                ADDR_TIMER:      rd_data = timer_cnt;
                ADDR_SCORE:      rd_data[15:0] = score_out;
                default:         rd_data = '0;
            endcase
        end
    end

    // RAM contents survive reset, but no write lands while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset && wren_dmem && is_ram)
            ram[ram_idx] <= d_dmem;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem      <= '0;
            led_out     <= '0;
            score_out   <= '0;
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
            btn_prev_p2 <= '0;
            btn_flags   <= '0;
            timer_cnt   <= '0;
            prescale    <= '0;
        end else begin
            q_dmem      <= rd_data;
            btn_sync_p0 <= btn_in;
            btn_sync_p1 <= btn_sync_p0;
            btn_prev_p2 <= btn_sync_p1;
            btn_flags   <= (btn_flags & ~status_clr) | btn_rise;
            if (wr_led)
                led_out <= d_dmem[NUM_BTN-1:0];
            if (wr_score)
                score_out <= d_dmem[15:0];
            if (wr_timer_clr) begin
                timer_cnt <= '0;
                prescale  <= '0;
            end else if (tick) begin
                timer_cnt <= timer_cnt + 32'd1;
                prescale  <= '0;
            end else begin
                prescale  <= prescale + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, unmapped space, buttons, timer, LED/score, reset.
module tb_dmem_mmio_responder;

    localparam int NUM_BTN = 9;

    logic               clock;
    logic               reset;
    logic [11:0]        address_dmem;
    logic [31:0]        d_dmem;
    logic               wren_dmem;
    logic [31:0]        q_dmem;
    logic [NUM_BTN-1:0] btn_in;
    logic [NUM_BTN-1:0] led_out;
    logic [15:0]        score_out;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_mmio_responder #(
        .RAM_WORDS(1024),
        .NUM_BTN  (NUM_BTN),
        .TICK_DIV (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .d_dmem      (d_dmem),
        .wren_dmem   (wren_dmem),
        .q_dmem      (q_dmem),
        .btn_in      (btn_in),
        .led_out     (led_out),
        .score_out   (score_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Present one access, let it be sampled, then sit 1 ns past the edge.
    task automatic access(input logic [11:0] addr, input logic we, input logic [31:0] d);
        address_dmem = addr;
        wren_dmem    = we;
        d_dmem       = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        address_dmem = 12'hE00;
        wren_dmem    = 1'b0;
        d_dmem       = '0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        address_dmem = 12'hE00;
        wren_dmem    = 1'b0;
        d_dmem       = '0;
        btn_in       = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_q", q_dmem, 32'h0);
        check("reset_led", 32'(led_out), 32'h0);
        check("reset_score", 32'(score_out), 32'h0);
        reset = 1'b0;

        // RAM write, read, and read-old-on-write
        access(12'h005, 1'b1, 32'hDEADBEEF);
        access(12'h005, 1'b0, 32'h0);
        check("ram_read", q_dmem, 32'hDEADBEEF);
        access(12'h005, 1'b1, 32'h00000001);
        check("ram_rd_old_on_wr", q_dmem, 32'hDEADBEEF);
        access(12'h005, 1'b0, 32'h0);
        check("ram_rewrite", q_dmem, 32'h00000001);

        // Unmapped writes are dropped; 0x400 must not alias onto RAM word 0
        access(12'h000, 1'b1, 32'h0000A5A5);
        access(12'hF0A, 1'b1, 32'h12345678);
        access(12'hF0A, 1'b0, 32'h0);
        check("unmapped_hi", q_dmem, 32'h0);
        access(12'h400, 1'b1, 32'h00000005);
        access(12'h400, 1'b0, 32'h0);
        check("unmapped_lo", q_dmem, 32'h0);
        access(12'h000, 1'b0, 32'h0);
        check("ram0_untouched", q_dmem, 32'h0000A5A5);
        access(12'hF06, 1'b0, 32'h0);
        check("unmapped_f06", q_dmem, 32'h0);

        // Button pulse -> sticky flag, cleared by read
        btn_in = 9'h004;
        idle(3);
        btn_in = '0;
        idle(3);
        access(12'hF00, 1'b0, 32'h0);
        check("btn_status", q_dmem, 32'h4);
        access(12'hF00, 1'b0, 32'h0);
        check("btn_status_cleared", q_dmem, 32'h0);

        // Held button: one flag only
        btn_in = 9'h004;
        idle(4);
        access(12'hF01, 1'b0, 32'h0);
        check("btn_level", q_dmem, 32'h4);
        access(12'hF00, 1'b0, 32'h0);
        check("btn_held_first", q_dmem, 32'h4);
        idle(3);
        access(12'hF00, 1'b0, 32'h0);
        check("btn_held_no_reset", q_dmem, 32'h0);
        btn_in = '0;
        idle(3);

        // Coincident set and clear: set wins for bit 0
        btn_in = 9'h002;
        idle(3);
        btn_in = '0;
        idle(3);
        btn_in = 9'h001;
        idle(2);
        access(12'hF00, 1'b0, 32'h0);
        check("coincident_read", q_dmem, 32'h2);
        access(12'hF00, 1'b0, 32'h0);
        check("coincident_survive", q_dmem, 32'h1);
        btn_in = '0;
        idle(3);

        // Write to BTN_STATUS neither clears nor stores
        btn_in = 9'h008;
        idle(2);
        btn_in = '0;
        idle(3);
        access(12'hF00, 1'b1, 32'hFFFFFFFF);
        check("status_write_q", q_dmem, 32'h8);
        access(12'hF00, 1'b0, 32'h0);
        check("status_after_write", q_dmem, 32'h8);
        access(12'hF00, 1'b0, 32'h0);
        check("status_cleared2", q_dmem, 32'h0);

        // Timer: 40 clocks after clear at TICK_DIV=4 -> 10
        access(12'hF04, 1'b1, 32'h0);
        idle(40);
        access(12'hF03, 1'b0, 32'h0);
        check("timer_40clk", q_dmem, 32'd10);
        // prescaler now 1; two idles bring it to 3, the clear lands on the tick
        idle(2);
        access(12'hF04, 1'b1, 32'h0);
        access(12'hF03, 1'b0, 32'h0);
        check("timer_clr_on_tick", q_dmem, 32'h0);
        access(12'hF04, 1'b0, 32'h0);
        check("timer_clr_reads0", q_dmem, 32'h0);

        // LED and SCORE
        access(12'hF02, 1'b1, 32'hFFFFFFFF);
        check("led_out", 32'(led_out), 32'h1FF);
        access(12'hF02, 1'b0, 32'h0);
        check("led_readback", q_dmem, 32'h1FF);
        access(12'hF05, 1'b1, 32'h0001ABCD);
        check("score_out", 32'(score_out), 32'h0000ABCD);
        access(12'hF05, 1'b0, 32'h0);
        check("score_readback", q_dmem, 32'h0000ABCD);
        access(12'hF01, 1'b1, 32'hFFFFFFFF);
        access(12'hF01, 1'b0, 32'h0);
        check("level_write_ignored", q_dmem, 32'h0);

        // Reset mid-stream with a pending flag and a running timer
        btn_in = 9'h010;
        idle(2);
        btn_in = '0;
        idle(7);
        access(12'h005, 1'b0, 32'h0);
        reset = 1'b1;
        idle(1);
        check("mid_reset_q", q_dmem, 32'h0);
        check("mid_reset_led", 32'(led_out), 32'h0);
        check("mid_reset_score", 32'(score_out), 32'h0);
        reset = 1'b0;
        access(12'hF03, 1'b0, 32'h0);
        check("mid_reset_timer", q_dmem, 32'h0);
        access(12'hF00, 1'b0, 32'h0);
        check("mid_reset_status", q_dmem, 32'h0);
        access(12'h005, 1'b0, 32'h0);
        check("ram_retained", q_dmem, 32'h00000001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
